// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the sram_arb2 two-port SRAM arbiter.
package sram_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned MACRO_DEPTH = 512;
  localparam int unsigned BYTE_W      = 8;

  // Active-high byte strobe to the macro's active-low per-bit write enables.
  function automatic logic [BYTE_W-1:0] strb_to_wen(input logic strb);
    return {BYTE_W{~strb}};
  endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way grant logic. SRAM_ARB_RR_EN selects round robin with a pointer
// register; otherwise port A has fixed priority and no state is kept.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef SRAM_ARB_RR_EN
  logic r_ptr;  // port that wins the next conflict

  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    o_gnt = '0;
    if (i_req[PORT_A] && (!i_req[PORT_B] || r_ptr == PORT_A))
      o_gnt[PORT_A] = 1'b1;
    else if (i_req[PORT_B])
      o_gnt[PORT_B] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= PORT_A;
    else if (o_gnt[PORT_A])
      r_ptr <= PORT_B;
    else if (o_gnt[PORT_B])
      r_ptr <= PORT_A;
  end
`else
  assign o_gnt[PORT_A] = i_req[PORT_A];
  assign o_gnt[PORT_B] = i_req[PORT_B] & ~i_req[PORT_A];
`endif

endmodule

// File: rtl/sram_arb2.sv
// Two-port arbiter/sequencer for a bank of ganged gf180mcu 512x8 SRAM macros.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed A priority.
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter  int N_MACROS = 4,
  parameter  int ADDR_W   = $clog2(MACRO_DEPTH),
  localparam int W        = BYTE_W * N_MACROS
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                a_valid,
  output logic                a_ready,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [N_MACROS-1:0] a_wstrb,
  input  logic [W-1:0]        a_wdata,
  output logic                a_rsp_valid,
  output logic [W-1:0]        a_rdata,

  input  logic                b_valid,
  output logic                b_ready,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [N_MACROS-1:0] b_wstrb,
  input  logic [W-1:0]        b_wdata,
  output logic                b_rsp_valid,
  output logic [W-1:0]        b_rdata,

  output logic                sram_cen,
  output logic                sram_gwen,
  output logic [W-1:0]        sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [W-1:0]        sram_d,
  input  logic [W-1:0]        sram_q
);

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  logic                w_write;
  logic [ADDR_W-1:0]   w_addr;
  logic [N_MACROS-1:0] w_wstrb;
  logic [W-1:0]        w_wdata;
  logic [W-1:0]        w_wen;
  logic [1:0]          r_rsp_own;

  assign w_req[PORT_A] = a_valid;
  assign w_req[PORT_B] = b_valid;

  sram_arb_rr2 u_arb (
`ifdef SRAM_ARB_RR_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign a_ready   = w_gnt[PORT_A];
  assign b_ready   = w_gnt[PORT_B];
  assign w_any_gnt = |w_gnt;

  // Port A's request drives the macro pins unless B holds the grant.
  always_comb begin
    w_write = a_write;
    w_addr  = a_addr;
    w_wstrb = a_wstrb;
    w_wdata = a_wdata;
    if (w_gnt[PORT_B]) begin
      w_write = b_write;
      w_addr  = b_addr;
      w_wstrb = b_wstrb;
      w_wdata = b_wdata;
    end
  end

  always_comb begin
    w_wen = '1;
    if (w_any_gnt && w_write)
      for (int i = 0; i < N_MACROS; i++)
        w_wen[i*BYTE_W +: BYTE_W] = strb_to_wen(w_wstrb[i]);
  end

  assign sram_cen  = ~w_any_gnt;
  assign sram_gwen = ~(w_any_gnt & w_write);
  assign sram_wen  = w_wen;
  assign sram_addr = w_addr;
  assign sram_d    = w_wdata;

  // Remembers who owns the macro output in the cycle after a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rsp_own <= '0;
    else
      r_rsp_own <= w_gnt;
  end

  assign a_rsp_valid = r_rsp_own[PORT_A];
  assign b_rsp_valid = r_rsp_own[PORT_B];
  assign a_rdata     = sram_q;
  assign b_rdata     = sram_q;

endmodule

// File: tb/tb_sram_arb2.sv
// Self-checking bench for sram_arb2: SRAM macro model, reference memory and
// per-port response scoreboards. Expectations follow SRAM_ARB_RR_EN if defined.
module tb_sram_arb2;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 9;

  typedef struct packed {
    logic         rd;
    logic [W-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          a_valid, a_write, b_valid, b_write;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [AW-1:0] a_addr, b_addr, sram_addr;
  logic [N-1:0]  a_wstrb, b_wstrb;
  logic [W-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic          sram_cen, sram_gwen;
  logic [W-1:0]  sram_wen, sram_d, sram_q;

  logic [W-1:0]  sram_mem [512];
  logic [W-1:0]  ref_mem  [512];
  exp_t          a_q[$];
  exp_t          b_q[$];
  logic          ptr_m;  // bench model of the round-robin pointer (0 = A)

  int n_checks = 0;
  int n_fail   = 0;
  int a_gnt_cnt, b_gnt_cnt, a_rsp_cnt, b_rsp_cnt;

  sram_arb2 #(.N_MACROS(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_write     (a_write),
    .a_addr      (a_addr),
    .a_wstrb     (a_wstrb),
    .a_wdata     (a_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rdata     (a_rdata),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_write     (b_write),
    .b_addr      (b_addr),
    .b_wstrb     (b_wstrb),
    .b_wdata     (b_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rdata     (b_rdata),
    .sram_cen    (sram_cen),
    .sram_gwen   (sram_gwen),
    .sram_wen    (sram_wen),
    .sram_addr   (sram_addr),
    .sram_d      (sram_d),
    .sram_q      (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 512xW macro bank: registered Q, bit-masked writes.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= sram_mem[sram_addr];
    end
  end

  task automatic drive_a(input logic v, input logic wr, input logic [AW-1:0] ad,
                         input logic [N-1:0] st, input logic [W-1:0] d);
    a_valid = v; a_write = wr; a_addr = ad; a_wstrb = st; a_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic wr, input logic [AW-1:0] ad,
                         input logic [N-1:0] st, input logic [W-1:0] d);
    b_valid = v; b_write = wr; b_addr = ad; b_wstrb = st; b_wdata = d;
  endtask

  task automatic ref_write(input logic [AW-1:0] ad, input logic [N-1:0] st,
                           input logic [W-1:0] d);
    for (int i = 0; i < N; i++)
      if (st[i]) ref_mem[ad][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // One clock: predict and check the grant, queue expected responses,
  // then after the edge compare each port's response against its queue.
  task automatic step();
    logic exp_a, exp_b;
    exp_t e;
    #1;
`ifdef SRAM_ARB_RR_EN
    exp_a = a_valid && (!b_valid || ptr_m == 1'b0);
`else
    exp_a = a_valid;
`endif
    exp_b = b_valid && !exp_a;
    n_checks += 3;
    if (a_ready !== exp_a) begin
      n_fail++; $display("FAIL a_ready: got %b expected %b @%0t", a_ready, exp_a, $time);
    end
    if (b_ready !== exp_b) begin
      n_fail++; $display("FAIL b_ready: got %b expected %b @%0t", b_ready, exp_b, $time);
    end
    if (sram_cen !== !(exp_a || exp_b)) begin
      n_fail++; $display("FAIL sram_cen: got %b expected %b @%0t", sram_cen, !(exp_a || exp_b), $time);
    end
    if (exp_a || exp_b) begin
      n_checks++;
      if (sram_addr !== (exp_b ? b_addr : a_addr)) begin
        n_fail++; $display("FAIL sram_addr: got %h expected %h", sram_addr, exp_b ? b_addr : a_addr);
      end
    end
    a_gnt_cnt += int'(a_ready === 1'b1);
    b_gnt_cnt += int'(b_ready === 1'b1);
    if (exp_a) begin
      e.rd = !a_write; e.data = ref_mem[a_addr];
      a_q.push_back(e);
      if (a_write) ref_write(a_addr, a_wstrb, a_wdata);
      ptr_m = 1'b1;
    end
    if (exp_b) begin
      e.rd = !b_write; e.data = ref_mem[b_addr];
      b_q.push_back(e);
      if (b_write) ref_write(b_addr, b_wstrb, b_wdata);
      ptr_m = 1'b0;
    end
    @(posedge clk);
    #1;
    a_rsp_cnt += int'(a_rsp_valid === 1'b1);
    b_rsp_cnt += int'(b_rsp_valid === 1'b1);
    n_checks += 2;
    if (a_q.size() > 0) begin
      e = a_q.pop_front();
      if (a_rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL a_rsp_valid: got %b expected 1 @%0t", a_rsp_valid, $time);
      end
      if (e.rd) begin
        n_checks++;
        if (a_rdata !== e.data) begin
          n_fail++; $display("FAIL a_rdata: got %h expected %h", a_rdata, e.data);
        end
      end
    end else if (a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL a_rsp_valid: got %b expected 0 @%0t", a_rsp_valid, $time);
    end
    if (b_q.size() > 0) begin
      e = b_q.pop_front();
      if (b_rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL b_rsp_valid: got %b expected 1 @%0t", b_rsp_valid, $time);
      end
      if (e.rd) begin
        n_checks++;
        if (b_rdata !== e.data) begin
          n_fail++; $display("FAIL b_rdata: got %h expected %h", b_rdata, e.data);
        end
      end
    end else if (b_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b_rsp_valid: got %b expected 0 @%0t", b_rsp_valid, $time);
    end
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ptr_m = 1'b0;
    idle();
    @(posedge clk);
    #1;
    n_checks += 3;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got a=%b b=%b expected 0/0", a_rsp_valid, b_rsp_valid);
    end
    if (sram_cen !== 1'b1) begin
      n_fail++; $display("FAIL reset_cen: got %b expected 1", sram_cen);
    end
    if (sram_wen !== '1) begin
      n_fail++; $display("FAIL reset_wen: got %h expected ffffffff", sram_wen);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    drive_a(1'b1, 1'b1, 9'h005, 4'hF, 32'hDEADBEEF);
    step();
    drive_a(1'b1, 1'b0, 9'h005, 4'h0, 32'h0);
    step();
    n_checks++;
    if (a_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rd_data: got %h expected deadbeef", a_rdata);
    end
    idle();
    step();
  endtask

  task automatic test_partial_write();
    drive_a(1'b1, 1'b1, 9'h1FF, 4'hF, 32'h11223344);
    step();
    idle();
    drive_b(1'b1, 1'b1, 9'h1FF, 4'h5, 32'hAABBCCDD);
    #1;
    n_checks += 2;
    if (sram_wen !== 32'hFF00FF00) begin
      n_fail++; $display("FAIL partial_wen: got %h expected ff00ff00", sram_wen);
    end
    if (sram_gwen !== 1'b0) begin
      n_fail++; $display("FAIL partial_gwen: got %b expected 0", sram_gwen);
    end
    step();
    drive_b(1'b1, 1'b0, 9'h1FF, 4'h0, 32'h0);
    step();
    n_checks++;
    if (b_rdata !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL partial_data: got %h expected 11bb33dd", b_rdata);
    end
    idle();
    step();
  endtask

  task automatic test_zero_strobe();
    drive_a(1'b1, 1'b1, 9'h1FF, 4'h0, 32'hFFFFFFFF);
    #1;
    n_checks++;
    if (sram_wen !== '1 || sram_cen !== 1'b0) begin
      n_fail++; $display("FAIL zero_strb_pins: got wen=%h cen=%b expected ffffffff/0", sram_wen, sram_cen);
    end
    step();
    drive_a(1'b1, 1'b0, 9'h1FF, 4'h0, 32'h0);
    step();
    n_checks++;
    if (a_rdata !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL zero_strb_data: got %h expected 11bb33dd", a_rdata);
    end
    idle();
    step();
  endtask

  task automatic test_contention();
    int exp_ga, exp_gb;
    drive_a(1'b1, 1'b1, 9'h000, 4'hF, 32'h0A0A0A0A);
    step();
    idle();
    drive_b(1'b1, 1'b1, 9'h001, 4'hF, 32'h0B0B0B0B);
    step();
    drive_a(1'b1, 1'b0, 9'h000, 4'h0, 32'h0);
    drive_b(1'b1, 1'b0, 9'h001, 4'h0, 32'h0);
    a_gnt_cnt = 0; b_gnt_cnt = 0; a_rsp_cnt = 0; b_rsp_cnt = 0;
    for (int i = 0; i < 8; i++) step();
`ifdef SRAM_ARB_RR_EN
    exp_ga = 4; exp_gb = 4;
`else
    exp_ga = 8; exp_gb = 0;
`endif
    n_checks += 2;
    if (a_gnt_cnt != exp_ga || b_gnt_cnt != exp_gb) begin
      n_fail++; $display("FAIL contention_grants: got A=%0d B=%0d expected A=%0d B=%0d",
                         a_gnt_cnt, b_gnt_cnt, exp_ga, exp_gb);
    end
    if (a_rsp_cnt != exp_ga || b_rsp_cnt != exp_gb) begin
      n_fail++; $display("FAIL contention_rsps: got A=%0d B=%0d expected A=%0d B=%0d",
                         a_rsp_cnt, b_rsp_cnt, exp_ga, exp_gb);
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 1'b1, 9'h0A0, 4'hF, 32'hCAFEF00D);
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b1, 1'b0, 9'h0A0, 4'h0, 32'h0);
    step();
    n_checks++;
    if (b_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL raw_data: got %h expected cafef00d", b_rdata);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 1'b0, 9'h005, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_grant: got %b expected 1", a_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_rsp: got a=%b b=%b expected 0/0", a_rsp_valid, b_rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 1'b0;
    a_q.delete();
    b_q.delete();
    step();
    drive_a(1'b1, 1'b0, 9'h005, 4'h0, 32'h0);
    drive_b(1'b1, 1'b0, 9'h1FF, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_grant: got a=%b b=%b expected 1/0", a_ready, b_ready);
    end
    step();
    drive_a(1'b0, 1'b0, '0, '0, '0);
    step();
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_zero_strobe();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arb2.md
Name: sram_arb2

Overview:
- Two-requester arbiter and sequencer for a bank of gf180mcu 512x8 SRAM macros, ganged into one 512 x (8*N_MACROS) word memory.
- Accepts single-beat read/write requests from port A (e.g. CPU) and port B (e.g. DMA/video).
- Drives the macro control pins (CEN, GWEN, per-bit WEN, A, D) and returns read data one cycle after grant.
- Sits between the system bus adapters and the macro instances.

Parameters:
- N_MACROS, 4, number of byte-wide macros ganged side by side; word width W = 8*N_MACROS.
- ADDR_W, 9, word address width; must match macro depth (512).

Ports:
- clk  in  1  single clock; also drives the macro CLK pins.
- rst  in  1  asynchronous reset, active-high.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_write  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  word address.
- a_wstrb  in  N_MACROS  byte write enables; active-high.
- a_wdata  in  W  write data.
- a_rsp_valid  out  1  one-cycle pulse, the cycle after acceptance.
- a_rdata  out  W  read data; valid with a_rsp_valid for reads.
- b_valid, b_ready, b_write, b_addr, b_wstrb, b_wdata, b_rsp_valid, b_rdata: same as port A, for port B.
- sram_cen  out  1  macro chip enable, active-low; shared by all macros.
- sram_gwen  out  1  macro global write enable, active-low.
- sram_wen  out  W  macro per-bit write enable, active-low.
- sram_addr  out  ADDR_W  macro address.
- sram_d  out  W  macro write data.
- sram_q  in  W  concatenated macro Q outputs; macro i drives bits [8i+7:8i].

Behaviour:
- Reset values (async assert, sync deassert handled upstream):
  - a_rsp_valid = b_rsp_valid = 0.
  - Round-robin pointer = "A has priority".
  - Response-owner register = none.
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - A requester holds valid, addr, write, wstrb and wdata stable until ready.
  - A requester must not drop valid before ready.
  - There is no response backpressure.
- Grant is combinational from the valid inputs and the RR pointer:
  - Only one port valid: that port gets ready = 1.
  - Both valid: the port indicated by the RR pointer is granted; the other sees ready = 0.
  - After any grant, the pointer moves to the non-granted port (round robin). Single-requester grants also flip the pointer to the other port.
- Macro drive is combinational from the granted request; the macro samples on the next clk posedge:
  - Grant: sram_cen = 0, sram_addr = granted addr, sram_gwen = !write.
  - Grant, write: sram_wen[8i+7:8i] = {8{!wstrb[i]}}, sram_d = wdata.
  - Grant, read: sram_wen = all-ones.
  - No grant: sram_cen = 1, sram_gwen = 1, sram_wen = all-ones. sram_addr and sram_d hold the port A values (no toggling requirement).
- Write with wstrb = 0: still granted and acknowledged; memory unchanged.
- Response:
  - The cycle after a granted transfer, the owner's x_rsp_valid = 1 for exactly one cycle, for both reads and writes.
  - x_rdata = sram_q in that cycle; write responses carry don't-care data.
  - Non-owner rsp_valid = 0.
  - a_rdata and b_rdata both wire to sram_q; only rsp_valid is steered.
- Latency and throughput:
  - One request per cycle sustained; zero-bubble back-to-back grants, alternating under contention.
  - Read-after-write to the same address on consecutive cycles returns the new data.
- Reset mid-operation: a pending response is dropped (rsp_valid forced 0); the macro may still complete the in-flight access.
- sram_q is undefined except the cycle after a read; the block never samples it otherwise.

Optional Feature:
- SRAM_ARB_RR_EN
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, port A always wins a conflict, and the RR pointer is not implemented. Port B starves while A is continuously valid, which is acceptable for a CPU-priority configuration.

Decomposition:
- Package sram_arb_pkg:
  - Port index constants PORT_A = 0, PORT_B = 1.
  - Localparams for macro depth 512 and byte width 8.
  - Strobe-to-WEN expansion function.
- One sub-module: sram_arb_rr2, the two-way grant logic plus pointer register. It is instantiated once, and its pointer-free fixed-priority path is selected by the macro.

Test Plan:
- Reset, then A writes addr 0x005, data 0xDEADBEEF, strobe 0xF; then A reads 0x005 -> a_ready = 1 both cycles, a_rsp_valid the cycle after each, read a_rdata = 0xDEADBEEF, b_rsp_valid stays 0.
- Write 0x11223344 to 0x1FF, then B writes 0xAABBCCDD with wstrb = 0x5, then reads -> b_rdata = 0x11BB33DD; sram_wen during the partial write = 0xFF00FF00.
- A and B both continuously valid reading 0x000/0x001 for 8 cycles -> grants alternate A,B,A,B... (RR_EN), each port gets 4 responses. Without RR_EN -> A granted all 8, b_ready = 0 throughout.
- A writes 0x0A0, 0xCAFEF00D and B reads 0x0A0 in the next cycle -> B's response returns 0xCAFEF00D.
- Assert rst in the cycle after a read grant -> a_rsp_valid = 0 that cycle. After release, sram_cen = 1 while idle, and the first contended grant goes to A.
